// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: line filtering, frame check, E0/F0 prefix decode, FWFT event FIFO.
// Optional inter-bit frame timeout enabled by defining PS2_FRAME_TIMEOUT_EN.
module ps2_key_event_rx #(
  parameter int SAMPLE_DIV  = 4,
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          evt_ready,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic [4:0]                    evt_hex,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]            clk_sync, dat_sync;
  logic [DW-1:0]         div_cnt;
  logic                  sample_stb;
  logic [FILTER_LEN-1:0] clk_flt, dat_flt;
  logic                  clk_f, dat_f, clk_f_d, clk_fall;

  assign sample_stb = (div_cnt == DW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      div_cnt  <= '0;
      clk_flt  <= '1;
      dat_flt  <= '1;
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_f_d  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      div_cnt  <= sample_stb ? '0 : div_cnt + 1'b1;
      if (sample_stb) begin
        clk_flt <= {clk_flt[FILTER_LEN-2:0], clk_sync[1]};
        dat_flt <= {dat_flt[FILTER_LEN-2:0], dat_sync[1]};
      end
      // Filtered lines only move on unanimous history, otherwise hold
      if (&clk_flt)       clk_f <= 1'b1;
      else if (~|clk_flt) clk_f <= 1'b0;
      if (&dat_flt)       dat_f <= 1'b1;
      else if (~|dat_flt) dat_f <= 1'b0;
      clk_f_d <= clk_f;
    end
  end

  assign clk_fall = clk_f_d & ~clk_f;

  state_t      state, state_n;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [7:0]  shreg, shreg_n;
  logic        par_bit, par_n;
  logic        byte_done, byte_done_n, frame_err_n;
  logic        tmo_hit;

`ifdef PS2_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state != S_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             tmo_cnt <= '0;
    else if (state == S_IDLE || clk_fall)  tmo_cnt <= '0;
    else if (!tmo_hit)                     tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    par_n       = par_bit;
    byte_done_n = 1'b0;
    frame_err_n = 1'b0;
    if (tmo_hit) begin
      state_n     = S_IDLE;
      frame_err_n = 1'b1;
    end else if (clk_fall) begin
      unique case (state)
        S_IDLE: begin
          if (!dat_f) begin
            state_n  = S_DATA;
            bitcnt_n = '0;
          end
        end
        S_DATA: begin
          shreg_n  = {dat_f, shreg[7:1]};
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == 3'd7) state_n = S_PARITY;
        end
        S_PARITY: begin
          par_n   = dat_f;
          state_n = S_STOP;
        end
        S_STOP: begin
          if (dat_f && (^{shreg, par_bit})) byte_done_n = 1'b1;
          else                              frame_err_n = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      par_bit   <= par_n;
      byte_done <= byte_done_n;
      frame_err <= frame_err_n;
    end
  end

  // shreg is stable for the byte_done cycle since the FSM is back in IDLE
  logic ext_flag, brk_flag, is_e0, is_f0, push;

  assign is_e0 = (shreg == 8'hE0);
  assign is_f0 = (shreg == 8'hF0);
  assign push  = byte_done && !is_e0 && !is_f0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (frame_err || push) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_done) begin
      if (is_e0) ext_flag <= 1'b1;
      if (is_f0) brk_flag <= 1'b1;
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, do_push;
  logic [9:0]    head;
  logic [4:0]    hex_raw;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = evt_valid && evt_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ext_flag, brk_flag, shreg};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign evt_valid  = (count != '0);
  assign fifo_count = count;
  assign evt_code   = evt_valid ? head[7:0] : '0;
  assign evt_break  = evt_valid & head[8];
  assign evt_ext    = evt_valid & head[9];

  always_comb begin
    hex_raw = 5'h1F;
    unique case (head[7:0])
      8'h45: hex_raw = 5'h00;
      8'h16: hex_raw = 5'h01;
      8'h1E: hex_raw = 5'h02;
      8'h26: hex_raw = 5'h03;
      8'h25: hex_raw = 5'h04;
      8'h2E: hex_raw = 5'h05;
      8'h36: hex_raw = 5'h06;
      8'h3D: hex_raw = 5'h07;
      8'h3E: hex_raw = 5'h08;
      8'h46: hex_raw = 5'h09;
      8'h1C: hex_raw = 5'h0A;
      8'h32: hex_raw = 5'h0B;
      8'h21: hex_raw = 5'h0C;
      8'h23: hex_raw = 5'h0D;
      8'h24: hex_raw = 5'h0E;
      8'h2B: hex_raw = 5'h0F;
      8'h5A: hex_raw = 5'h10;
      8'h66: hex_raw = 5'h11;
      8'h0D: hex_raw = 5'h12;
      default: hex_raw = 5'h1F;
    endcase
  end

  assign evt_hex = evt_valid ? hex_raw : 5'h1F;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Bench for ps2_key_event_rx: drives PS/2 frames, compares events against a queue-based model.
module tb_ps2_key_event_rx;

  localparam int HALF  = 50;     // clk cycles per PS/2 clock half period
  localparam int TMO   = 1500;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn, ps2_clk, ps2_data, evt_ready;
  logic       evt_valid, evt_ext, evt_break, frame_err, overflow;
  logic [7:0] evt_code;
  logic [4:0] evt_hex;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  ps2_key_event_rx #(
    .SAMPLE_DIV(4), .FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .evt_hex(evt_hex),
    .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow)
  );

  int n_chk = 0, n_fail = 0;
  int ferr_cnt = 0, ovf_cnt = 0;
  int exp_ferr = 0, exp_ovf = 0;
  logic [14:0] rx_q[$];
  int rx_rd = 0;
  logic [9:0] exp_q[$];
  bit m_ext = 0, m_brk = 0;
  logic [7:0] keys [19] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h5A, 8'h66, 8'h0D};

  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
      if (evt_valid && evt_ready) rx_q.push_back({evt_hex, evt_ext, evt_break, evt_code});
    end
  end

  function automatic logic [4:0] hex_of(input logic [7:0] c);
    for (int i = 0; i < 19; i++) if (keys[i] == c) return 5'(i);
    return 5'h1F;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_ferr++; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (exp_q.size() == DEPTH) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); m_ext = 0; m_brk = 0;
    rx_rd = rx_q.size();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(HALF); ps2_clk = 1'b0;
      tick(HALF); ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(2 * HALF);
    if (nbits == 11) model_byte(b, bad);
  endtask

  task automatic drain_fifo(input string tag);
    int k = 0;
    logic [14:0] want;
    evt_ready = 1'b1;
    while (evt_valid && k < 40) begin tick(1); k++; end
    evt_ready = 1'b0;
    n_chk++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drain_timeout: valid=%b required 0", tag, evt_valid); end
    n_chk++;
    if (rx_q.size() - rx_rd != exp_q.size()) begin
      n_fail++; $display("FAIL %s_event_count: got %0d required %0d", tag, rx_q.size() - rx_rd, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (rx_rd < rx_q.size()) begin
        want = {hex_of(exp_q[i][7:0]), exp_q[i]};
        n_chk++;
        if (rx_q[rx_rd] !== want) begin
          n_fail++; $display("FAIL %s_event%0d: got {hex,ext,brk,code}=%h required %h", tag, i, rx_q[rx_rd], want);
        end
        rx_rd++;
      end
    end
    n_chk++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL %s_count_after: got %0d required 0", tag, fifo_count); end
    exp_q.delete();
    rx_rd = rx_q.size();
  endtask

  task automatic test_reset();
    rstn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0;
    tick(5);
    n_chk++;
    if ({evt_valid, evt_code, evt_ext, evt_break, fifo_count, frame_err, overflow} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b c=%h e=%b b=%b n=%0d fe=%b ov=%b required all 0",
                         evt_valid, evt_code, evt_ext, evt_break, fifo_count, frame_err, overflow);
    end
    n_chk++;
    if (evt_hex !== 5'h1F) begin n_fail++; $display("FAIL reset_hex: got %h required 1f", evt_hex); end
    rstn = 1'b1;
    tick(60);
    n_chk++;
    if (evt_valid !== 1'b0 || ferr_cnt != 0) begin
      n_fail++; $display("FAIL idle_after_reset: valid=%b frame_err_pulses=%0d required 0/0", evt_valid, ferr_cnt);
    end
  endtask

  task automatic test_make();
    send_frame(8'h45, 0, 11);
    n_chk++;
    if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL make_count: got %0d required 1", fifo_count); end
    n_chk++;
    if (evt_code !== 8'h45 || evt_hex !== 5'h00) begin
      n_fail++; $display("FAIL make_head: got code=%h hex=%h required 45/00", evt_code, evt_hex);
    end
    drain_fifo("make");
  endtask

  task automatic test_prefixes();
    send_frame(8'hF0, 0, 11);
    n_chk++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL f0_alone: valid=%b required 0", evt_valid); end
    send_frame(8'h1C, 0, 11);
    drain_fifo("break");
    send_frame(8'hE0, 0, 11);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h5A, 0, 11);
    drain_fifo("ext_break");
  endtask

  task automatic test_parity();
    send_frame(8'h16, 1, 11);
    n_chk++;
    if (ferr_cnt != exp_ferr) begin n_fail++; $display("FAIL parity_err: got %0d pulses required %0d", ferr_cnt, exp_ferr); end
    n_chk++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL parity_no_event: valid=%b required 0", evt_valid); end
    send_frame(8'h16, 0, 11);
    drain_fifo("parity_retry");
  endtask

  task automatic test_overflow();
    logic [7:0] seq [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    foreach (seq[i]) send_frame(seq[i], 0, 11);
    n_chk++;
    if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d required 4", fifo_count); end
    n_chk++;
    if (ovf_cnt != exp_ovf || exp_ovf != 1) begin
      n_fail++; $display("FAIL ovf_pulse: got %0d pulses required %0d", ovf_cnt, exp_ovf);
    end
    tick(20);
    n_chk++;
    if (evt_valid !== 1'b1 || evt_code !== 8'h16 || evt_hex !== 5'h01) begin
      n_fail++; $display("FAIL ovf_head_held: got v=%b code=%h hex=%h required 1/16/01", evt_valid, evt_code, evt_hex);
    end
    drain_fifo("overflow");
  endtask

  task automatic test_glitch();
    int fe0 = ferr_cnt;
    ps2_clk = 1'b0; tick(12); ps2_clk = 1'b1;
    tick(200);
    n_chk++;
    if (evt_valid !== 1'b0 || ferr_cnt != fe0) begin
      n_fail++; $display("FAIL glitch_quiet: valid=%b frame_err_pulses=%0d required 0/%0d", evt_valid, ferr_cnt, fe0);
    end
    send_frame(8'h46, 0, 11);
    drain_fifo("glitch_next");
  endtask

  task automatic test_midframe_reset();
    send_frame(8'h1E, 0, 11);
    send_frame(8'h36, 0, 5);
    rstn = 1'b0; tick(3);
    n_chk++;
    if (evt_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL midreset_flush: valid=%b count=%0d required 0/0", evt_valid, fifo_count);
    end
    rstn = 1'b1; model_reset();
    tick(60);
    send_frame(8'h26, 0, 11);
    drain_fifo("midreset_next");
  endtask

`ifdef PS2_FRAME_TIMEOUT_EN
  task automatic test_timeout();
    send_frame(8'hE0, 0, 11);
    send_frame(8'h3D, 0, 5);
    tick(TMO + 200);
    exp_ferr++; m_ext = 0; m_brk = 0;
    n_chk++;
    if (ferr_cnt != exp_ferr) begin n_fail++; $display("FAIL timeout_err: got %0d pulses required %0d", ferr_cnt, exp_ferr); end
    send_frame(8'h3D, 0, 11);
    drain_fifo("timeout_next");
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(3, 6);
      for (int f = 0; f < n; f++) begin
        int sel = $urandom_range(0, 9);
        logic [7:0] b;
        if (sel < 2)      b = 8'hE0;
        else if (sel < 4) b = 8'hF0;
        else if (sel < 8) b = keys[$urandom_range(0, 18)];
        else              b = 8'($urandom);
        send_frame(b, ($urandom_range(0, 7) == 0), 11);
      end
      n_chk++;
      if (ferr_cnt != exp_ferr) begin n_fail++; $display("FAIL rand%0d_frame_err: got %0d required %0d", r, ferr_cnt, exp_ferr); end
      n_chk++;
      if (ovf_cnt != exp_ovf) begin n_fail++; $display("FAIL rand%0d_overflow: got %0d required %0d", r, ovf_cnt, exp_ovf); end
      n_chk++;
      if (fifo_count !== 3'(exp_q.size())) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d required %0d", r, fifo_count, exp_q.size());
      end
      drain_fifo("random");
    end
  endtask

  task automatic test_back_to_back();
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(keys[$urandom_range(0, 18)], 0, 11);
    drain_fifo("streaming");
  endtask

  initial begin
    test_reset();
    test_make();
    test_prefixes();
    test_parity();
    test_overflow();
    test_glitch();
    test_midframe_reset();
`ifdef PS2_FRAME_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
